apb_timer: RTL
==============

// Module: apb_timer
// PURPOSE
//  APB slave peripheral: programmable up-counter timer with prescaler, auto-reload and interrupt.
//  Sits directly downstream of the APB master; occupies one PSELx slot (e.g. 0x1000_2xxx).
//  Drives its own PRDATA/PREADY back into the master's read mux.
//  Raises irq_o to the core on counter update (overflow).
// PARAMETERS
//  CNT_W   32  width of prescaler, auto-reload and counter registers (1..32)
//  ADDR_W  12  PADDR bits decoded by this slave (byte address within the slot)
// PORTS
//  PCLK     in   1       sole clock; all logic on posedge
//  PRESET   in   1       synchronous, active-high reset
//  PADDR    in   ADDR_W  byte address; only PADDR[4:2] decoded, [1:0] ignored
//  PWDATA   in   32      write data
//  PWRITE   in   1       1 = write, 0 = read
//  PENABLE  in   1       APB access phase
//  PSEL     in   1       slave select from master decoder
//  PRDATA   out  32      read data, registered
//  PREADY   out  1       transfer complete, registered
//  irq_o    out  1       interrupt, level: STATUS.UIF & CTRL.IE
//  pwm_o    out  1       compare output (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all registers 0, PRDATA=0, PREADY=0, irq_o=0, pwm_o=0, slave FSM=IDLE.
//  Slave FSM IDLE/ACK: IDLE & PSEL & PENABLE -> ACK; ACK -> IDLE unconditionally.
//   PREADY=1 only in ACK: exactly one wait state; every transfer completes in 3 PCLK incl. SETUP.
//   Write commits on the ACK edge; PRDATA is loaded on the IDLE->ACK edge and held until the next read.
//   PSEL dropped in IDLE: no action. Reset mid-transfer: back to IDLE, no write commits.
//  Register map (offset): 0x00 CTRL [0]EN [1]IE [2]ONESHOT; 0x04 PSC; 0x08 ARR; 0x0C CNT (R/W);
//   0x10 STATUS [0]UIF, write-1-to-clear; 0x14 CMP (optional). Unused bits read 0.
//   Unmapped offsets read 0; writes to them are ignored. PREADY still asserts.
//  Counting (EN=1): psc_cnt counts 0..PSC; psc_cnt==PSC gives a tick and psc_cnt<=0.
//   On tick: CNT==ARR -> CNT<=0, UIF<=1, and EN<=0 if ONESHOT; otherwise CNT<=CNT+1.
//   PSC=0 ticks every cycle. ARR=0 gives an update on every tick. Wrap is modulo 2^CNT_W.
//  EN=0: psc_cnt and CNT hold their values. Writing EN 0->1 clears psc_cnt, not CNT.
//  Simultaneous events:
//   UIF set and W1C in the same cycle -> set wins.
//   APB write to CNT on a tick cycle -> the written value wins.
//   Write to PSC -> psc_cnt<=0.
//  irq_o is combinational from registers, so it follows UIF/IE with 0 extra latency.
// CONFIGURATION
//  APB_TIMER_CMP_EN defined: CMP register at 0x14 (R/W, CNT_W bits); pwm_o = EN & (CNT < CMP), registered.
//  APB_TIMER_CMP_EN undefined: 0x14 is unmapped (reads 0), pwm_o tied 0. The port exists in both builds.
// STRUCTURE
//  apb_timer_pkg:
//   register offset localparams, CTRL/STATUS bit indices;
//   typedef enum {IDLE, ACK} apb_slv_state_e.
//  Sub-module apb_timer_core: prescaler + counter + UIF set logic.
//   Inputs: en, psc, arr, cnt load/value.
//   Outputs: cnt, update pulse, oneshot clear of EN.
//  Top level: APB slave FSM, register file, read mux, irq/pwm.
// TESTING
//  1 Reset: assert PRESET 2 cycles -> all reads return 0, PREADY=0, irq_o=0.
//  2 APB write 0x04=3, read back -> PRDATA=3; PREADY high exactly 1 cycle, 3rd cycle of the transfer.
//  3 PSC=0, ARR=4, CTRL=0x3 -> CNT 0,1,2,3,4,0; UIF=1 and irq_o=1 on the wrap.
//    Write 0x10=1 -> irq_o=0 next cycle.
//  4 PSC=2, ARR=1, CTRL=0x5 (oneshot) -> CNT increments every 3 cycles;
//    after 6 cycles UIF=1, CTRL.EN reads 0, CNT held at 0.
//  5 W1C to STATUS on the exact update cycle -> UIF remains 1.
//    Write CNT=7 on a tick cycle -> CNT reads 7.
//  6 Read offset 0x18 -> 0, write there has no effect.
//    With APB_TIMER_CMP_EN: CMP=2, ARR=3, PSC=0 -> pwm_o 1,1,0,0 repeating.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register word offsets, bit positions, slave FSM states.
package apb_timer_pkg;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PSC    = 3'd1;
  localparam logic [2:0] OFF_ARR    = 3'd2;
  localparam logic [2:0] OFF_CNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CMP    = 3'd5;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_OS  = 2;
  localparam int STAT_UIF = 0;

  typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} apb_slv_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaler and auto-reload up-counter; flags the update (wrap) event to the register file.
module apb_timer_core #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             oneshot,
  input  logic             psc_clr,
  input  logic             cnt_ld,
  input  logic [CNT_W-1:0] psc,
  input  logic [CNT_W-1:0] arr,
  input  logic [CNT_W-1:0] cnt_wdata,
  output logic [CNT_W-1:0] cnt,
  output logic             upd,
  output logic             en_clr
);

  logic [CNT_W-1:0] psc_cnt;
  logic             tick;

  assign tick   = en && (psc_cnt == psc);
  assign upd    = tick && (cnt == arr);
  assign en_clr = upd && oneshot;

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (psc_clr)    psc_cnt <= '0;
      else if (tick)  psc_cnt <= '0;
      else if (en)    psc_cnt <= psc_cnt + CNT_W'(1);
      // A bus write to CNT overrides the tick in the same cycle
      if (cnt_ld)     cnt <= cnt_wdata;
      else if (tick)  cnt <= (cnt == arr) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB slave timer: one-wait-state slave FSM, register file, read mux, irq and optional compare output.
// Define APB_TIMER_CMP_EN to add the CMP register at 0x14 and drive pwm_o.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              irq_o,
  output logic              pwm_o
);

  apb_slv_state_e   state, state_nx;
  logic [2:0]       idx;
  logic             wr, rd_ld;
  logic             we_ctrl, we_psc, we_arr, we_cnt, we_stat;
  logic             ctrl_en, ctrl_ie, ctrl_os, uif;
  logic [CNT_W-1:0] psc, arr, cnt;
  logic             upd, en_clr, psc_clr;
  logic [31:0]      rd_mux;
  logic             unused;

  assign unused = ^{PADDR, PWDATA};

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (PSEL && PENABLE) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign idx     = PADDR[4:2];
  assign wr      = (state == ACK) && PSEL && PWRITE;
  assign rd_ld   = (state == IDLE) && PSEL && PENABLE && !PWRITE;
  assign we_ctrl = wr && (idx == OFF_CTRL);
  assign we_psc  = wr && (idx == OFF_PSC);
  assign we_arr  = wr && (idx == OFF_ARR);
  assign we_cnt  = wr && (idx == OFF_CNT);
  assign we_stat = wr && (idx == OFF_STATUS);
  // Prescaler restarts on a new PSC value or when the timer is switched on
  assign psc_clr = we_psc || (we_ctrl && PWDATA[CTRL_EN] && !ctrl_en);

  apb_timer_core #(.CNT_W(CNT_W)) u_core (
    .clk       (PCLK),
    .rst       (PRESET),
    .en        (ctrl_en),
    .oneshot   (ctrl_os),
    .psc_clr   (psc_clr),
    .cnt_ld    (we_cnt),
    .psc       (psc),
    .arr       (arr),
    .cnt_wdata (PWDATA[CNT_W-1:0]),
    .cnt       (cnt),
    .upd       (upd),
    .en_clr    (en_clr)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      ctrl_os <= 1'b0;
      psc     <= '0;
      arr     <= '0;
      uif     <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
    end else begin
      if (we_ctrl) begin
        ctrl_en <= PWDATA[CTRL_EN];
        ctrl_ie <= PWDATA[CTRL_IE];
        ctrl_os <= PWDATA[CTRL_OS];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (we_psc) psc <= PWDATA[CNT_W-1:0];
      if (we_arr) arr <= PWDATA[CNT_W-1:0];
      if (upd)                              uif <= 1'b1;
      else if (we_stat && PWDATA[STAT_UIF]) uif <= 1'b0;
      if (rd_ld) PRDATA <= rd_mux;
      PREADY <= (state_nx == ACK);
    end
  end

`ifdef APB_TIMER_CMP_EN
  logic [CNT_W-1:0] cmp;
  logic             pwm_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmp   <= '0;
      pwm_q <= 1'b0;
    end else begin
      if (wr && (idx == OFF_CMP)) cmp <= PWDATA[CNT_W-1:0];
      pwm_q <= ctrl_en && (cnt < cmp);
    end
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFF_CTRL:   rd_mux = 32'({ctrl_os, ctrl_ie, ctrl_en});
      OFF_PSC:    rd_mux = 32'(psc);
      OFF_ARR:    rd_mux = 32'(arr);
      OFF_CNT:    rd_mux = 32'(cnt);
      OFF_STATUS: rd_mux = 32'(uif);
`ifdef APB_TIMER_CMP_EN
      OFF_CMP:    rd_mux = 32'(cmp);
`endif
      default:    rd_mux = '0;
    endcase
  end

  assign irq_o = uif && ctrl_ie;

endmodule
